// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and types for the SRAM port arbiter.
//   REQ_SPI/REQ_DATA/REQ_INSTR : fixed requester indices
//   N_REQ_DEF                  : default requester count
//   BE_W                       : byte-enable width of one 32-bit word
//   req_idx_t                  : requester index for the default count
//   idx_w()                    : index width helper (never below 1 bit)
package mem_arb_pkg;

  localparam int REQ_SPI   = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_INSTR = 2;
  localparam int N_REQ_DEF = 3;
  localparam int BE_W      = 4;

  typedef logic [$clog2(N_REQ_DEF)-1:0] req_idx_t;

  // $clog2(1) is 0, which would give a zero-width index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : request vector
//   last : index granted most recently; search starts at last+1 and wraps
//   gnt  : one-hot grant (zero when req is zero)
//   idx  : index of the granted bit
//   any  : at least one request present
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // k = N wraps back onto last itself, so a lone repeat requester still wins.
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port core SRAM between the SPI
// loader (0), the core data port (1) and the core instruction port (2).
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_i/we_i           per-requester request and write enable
//   be_i/addr_i/wdata_i  per-requester byte enables, byte address, data,
//                        packed as slice i = bits [W*i +: W]
//   gnt_o                one-hot grant, combinational in the request cycle
//   rvalid_o/rdata_o/err_o  response one cycle after the grant
//   mem_*                SRAM macro interface (word addressed)
//
// Grants are combinational; the response for a grant is presented the
// next cycle, so a new grant can be issued every cycle.  Out-of-window
// addresses are still granted but never reach the SRAM; they complete
// with err_o set and rdata_o = 0.
//
// Build option MEM_ARB_SPI_PRIO_EN: SPI (index 0) wins whenever it
// requests; the remaining requesters rotate among themselves only.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                N_REQ     = N_REQ_DEF,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE  = '0,
  parameter int                MEM_WORDS = 1024,
  localparam int               AW        = $clog2(MEM_WORDS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         we_i,
  input  logic [BE_W*N_REQ-1:0]    be_i,
  input  logic [ADDR_W*N_REQ-1:0]  addr_i,
  input  logic [DATA_W*N_REQ-1:0]  wdata_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     err_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [BE_W-1:0]          mem_be_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic [DATA_W-1:0]        mem_rdata_i
);

  localparam int                IW      = idx_w(N_REQ);
  localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(MEM_WORDS);

  // Per-requester views of the flattened buses.
  logic [N_REQ-1:0][BE_W-1:0]   be_a;
  logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [N_REQ-1:0][DATA_W-1:0] wdata_a;

  assign be_a    = be_i;
  assign addr_a  = addr_i;
  assign wdata_a = wdata_i;

  logic [IW-1:0]    last_q;
  logic [IW-1:0]    win;
  logic [N_REQ-1:0] gnt;
  logic             any_gnt;
  logic             last_upd;

  // ---------------------------------------------------------------- arbitration
`ifdef MEM_ARB_SPI_PRIO_EN
  logic [N_REQ-1:0] rr_req, rr_gnt;
  logic [IW-1:0]    rr_idx;
  logic             rr_any;
  logic [1:0]       lvl_gnt;
  logic             lvl_idx;

  // Rotation among the non-SPI requesters only.
  assign rr_req = {req_i[N_REQ-1:1], 1'b0};

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr (
    .req (rr_req),
    .last(last_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Two-level pick: last fixed at 1 makes the search start at slot 0,
  // turning this instance into a fixed SPI-first priority stage.
  rr_pick #(.N(2), .IW(1)) u_spi (
    .req ({rr_any, req_i[REQ_SPI]}),
    .last(1'b1),
    .gnt (lvl_gnt),
    .idx (lvl_idx),
    .any (any_gnt)
  );

  assign gnt      = lvl_gnt[1] ? rr_gnt : {{(N_REQ-1){1'b0}}, lvl_gnt[0]};
  assign win      = lvl_idx ? rr_idx : IW'(REQ_SPI);
  // SPI grants leave the rotation pointer alone.
  assign last_upd = any_gnt & lvl_idx;
`else
  rr_pick #(.N(N_REQ), .IW(IW)) u_rr (
    .req (req_i),
    .last(last_q),
    .gnt (gnt),
    .idx (win),
    .any (any_gnt)
  );

  assign last_upd = any_gnt;
`endif

  // ---------------------------------------------------------------- decode
  logic [ADDR_W-1:0] addr_w, off, word;
  logic              in_range;

  assign addr_w   = addr_a[win];
  assign off      = addr_w - MEM_BASE;
  assign word     = off >> 2;
  // The lower-bound test catches subtraction underflow.
  assign in_range = (addr_w >= MEM_BASE) && (word < WORDS_A);

  // ---------------------------------------------------------------- SRAM side
  // Everything is gated by mem_req_o so the macro pins sit at 0 when idle
  // or when the winner is outside the window (its write is dropped).
  assign gnt_o       = gnt;
  assign mem_req_o   = any_gnt & in_range;
  assign mem_we_o    = mem_req_o & we_i[win];
  assign mem_be_o    = mem_req_o ? be_a[win]    : '0;
  assign mem_addr_o  = mem_req_o ? word[AW-1:0] : '0;
  assign mem_wdata_o = mem_req_o ? wdata_a[win] : '0;

  // ---------------------------------------------------------------- response
  // owner_q holds the winner as a one-hot copy of the grant so it can drive
  // rvalid_o directly.
  logic [N_REQ-1:0] owner_q;
  logic             vld_q, err_q, rd_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q  <= IW'(N_REQ-1);
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      owner_q <= '0;
    end else begin
      if (last_upd) last_q <= win;
      vld_q   <= any_gnt;
      err_q   <= any_gnt & ~in_range;
      rd_q    <= mem_req_o & ~mem_we_o;
      owner_q <= gnt;
    end
  end

  // Reset also masks the response combinationally so a response already in
  // flight when reset is asserted never appears.
  logic rsp_on;
  assign rsp_on   = vld_q & rst_ni;
  assign rvalid_o = rsp_on ? owner_q : '0;
  assign err_o    = rsp_on & err_q;
  assign rdata_o  = (rsp_on & rd_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, a behavioural SRAM, and a
// per-cycle reference model (priority search + reference memory) checked
// on every falling edge.
module tb_mem_port_arbiter;

  localparam int N     = 3;
  localparam int WORDS = 1024;

  logic        clk    = 1'b0;
  logic        rst_ni = 1'b0;
  logic [2:0]  req_i  = '0;
  logic [2:0]  we_i   = '0;
  logic [11:0] be_i   = '0;
  logic [95:0] addr_i = '0;
  logic [95:0] wdata_i = '0;
  logic [2:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o, mem_wdata_o;
  logic        err_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_be_o   (mem_be_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural SRAM macro.
  logic [31:0] sram   [WORDS];
  logic [31:0] refmem [WORDS];

  initial for (int i = 0; i < WORDS; i++) begin
    sram[i]   = '0;
    refmem[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
      mem_rdata_i <= sram[mem_addr_o];
    end
  end

  // Reference model: state valid between rising edges; checked and then
  // advanced on each falling edge (inputs are stable until the next rise).
  int          m_last = N-1;
  bit          p_vld  = 0;
  int          p_own  = 0;
  bit          p_err  = 0;
  bit          p_rd   = 0;
  logic [31:0] p_data = '0;

  always @(negedge clk) begin : model
    int          w, j, widx;
    logic [31:0] a, off;
    bit          inr, rsp;
    w = -1; inr = 0; a = '0; off = '0; widx = 0;
    for (int k = 1; k <= N; k++) begin
      j = (m_last + k) % N;
`ifdef MEM_ARB_SPI_PRIO_EN
      if (w < 0 && j != 0 && req_i[j]) w = j;
`else
      if (w < 0 && req_i[j]) w = j;
`endif
    end
`ifdef MEM_ARB_SPI_PRIO_EN
    if (req_i[0]) w = 0;
`endif
    chk("gnt", gnt_o, (w >= 0) ? (32'd1 << w) : 32'd0);
    if (w >= 0) begin
      a    = addr_i[32*w +: 32];
      off  = a - 32'h0;
      inr  = (a >= 32'h0) && ((off >> 2) < WORDS);
      widx = int'(off >> 2);
    end
    chk("mem_req", mem_req_o, 32'(w >= 0 && inr));
    if (w >= 0 && inr) begin
      chk("mem_addr", mem_addr_o, off >> 2);
      chk("mem_we", mem_we_o, we_i[w]);
      chk("mem_be", mem_be_o, be_i[4*w +: 4]);
      chk("mem_wdata", mem_wdata_o, wdata_i[32*w +: 32]);
    end
    rsp = rst_ni && p_vld;
    chk("rvalid", rvalid_o, rsp ? (32'd1 << p_own) : 32'd0);
    chk("err", err_o, 32'(rsp && p_err));
    chk("rdata", rdata_o, (rsp && p_rd) ? p_data : 32'd0);

    if (!rst_ni) begin
      m_last = N-1;
      p_vld  = 0;
    end else begin
      p_vld = (w >= 0);
      p_own = (w >= 0) ? w : 0;
      p_err = (w >= 0) && !inr;
      p_rd  = (w >= 0) && inr && !we_i[w];
      if (w >= 0 && inr) begin
        p_data = refmem[widx];
        if (we_i[w])
          for (int b = 0; b < 4; b++)
            if (be_i[4*w + b]) refmem[widx][8*b +: 8] = wdata_i[32*w + 8*b +: 8];
      end
`ifdef MEM_ARB_SPI_PRIO_EN
      if (w > 0) m_last = w;
`else
      if (w >= 0) m_last = w;
`endif
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic at_neg;
    @(negedge clk); #1;
  endtask

  task automatic set_req(input int i, input bit w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
    req_i[i]            = 1'b1;
    we_i[i]             = w;
    be_i[4*i +: 4]      = b;
    addr_i[32*i +: 32]  = a;
    wdata_i[32*i +: 32] = d;
  endtask

  task automatic clr;
    req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) step;
    at_neg;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_err", err_o, 0);
    step; rst_ni = 1'b1;

    // SPI write 0x80 <= 0xfff, then instruction read of it
    set_req(0, 1, 4'hF, 32'h80, 32'h0000_0fff);
    at_neg;
    chk("spi_gnt", gnt_o, 3'b001);
    chk("spi_addr", mem_addr_o, 10'h20);
    chk("spi_we", mem_we_o, 1);
    step; clr;
    at_neg;
    chk("spi_rvalid", rvalid_o, 3'b001);
    chk("spi_err", err_o, 0);
    step; set_req(2, 0, 4'hF, 32'h80, 0);
    at_neg;
    chk("ird_gnt", gnt_o, 3'b100);
    step; clr;
    at_neg;
    chk("ird_rvalid", rvalid_o, 3'b100);
    chk("ird_rdata", rdata_o, 32'h0000_0fff);

    // Unaligned address ignores bits [1:0]
    step; set_req(1, 0, 4'hF, 32'h83, 0);
    at_neg;
    chk("unal_addr", mem_addr_o, 10'h20);
    step; clr;
    at_neg;
    chk("unal_rdata", rdata_o, 32'h0000_0fff);

    // All three requesting from reset: 0,1,2,0,1,2
    step; rst_ni = 1'b0;
    step; rst_ni = 1'b1;
    set_req(0, 0, 4'hF, 32'h0, 0);
    set_req(1, 0, 4'hF, 32'h4, 0);
    set_req(2, 0, 4'hF, 32'h8, 0);
    for (int k = 0; k < 6; k++) begin
      at_neg;
      chk("rr_gnt", gnt_o, 32'd1 << (k % 3));
      if (k > 0) chk("rr_rvalid", rvalid_o, 32'd1 << ((k - 1) % 3));
      step;
    end
    clr;

    // Out-of-range read (word 1024)
    set_req(1, 0, 4'hF, 32'h0000_1000, 0);
    at_neg;
    chk("oob_gnt", gnt_o, 3'b010);
    chk("oob_mem_req", mem_req_o, 0);
    step; clr;
    at_neg;
    chk("oob_rvalid", rvalid_o, 3'b010);
    chk("oob_err", err_o, 1);
    chk("oob_rdata", rdata_o, 0);

    // Out-of-range write is discarded
    step; set_req(0, 1, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF);
    at_neg;
    chk("oobw_mem_req", mem_req_o, 0);
    step; clr;
    at_neg;
    chk("oobw_err", err_o, 1);

    // Byte write then back-to-back read: 0xAABBCCDD with be 0010 -> 0x0000CC00
    step; set_req(1, 1, 4'b0010, 32'h100, 32'hAABB_CCDD);
    at_neg;
    chk("bw_gnt", gnt_o, 3'b010);
    chk("bw_be", mem_be_o, 4'b0010);
    step; clr; set_req(2, 0, 4'hF, 32'h100, 0);
    at_neg;
    chk("bw_rd_gnt", gnt_o, 3'b100);
    chk("bw_wr_rvalid", rvalid_o, 3'b010);
    step; clr;
    at_neg;
    chk("bw_rd_rvalid", rvalid_o, 3'b100);
    chk("bw_rdata", rdata_o, 32'h0000_CC00);

    // Reset right after a data-port grant drops the response
    step; set_req(1, 0, 4'hF, 32'h4, 0);
    at_neg;
    chk("rm_gnt", gnt_o, 3'b010);
    step; clr; rst_ni = 1'b0;
    at_neg;
    chk("rm_rvalid", rvalid_o, 0);
    step; rst_ni = 1'b1;
    set_req(0, 0, 4'hF, 32'h0, 0);
    set_req(2, 0, 4'hF, 32'h8, 0);
    at_neg;
    chk("rm_restart_gnt", gnt_o, 3'b001);
    step; clr;
    at_neg;
    chk("rm_restart_rvalid", rvalid_o, 3'b001);

`ifdef MEM_ARB_SPI_PRIO_EN
    // SPI wins every cycle; without it, 1 and 2 alternate
    step; rst_ni = 1'b0;
    step; rst_ni = 1'b1;
    set_req(0, 0, 4'hF, 32'h0, 0);
    set_req(1, 0, 4'hF, 32'h4, 0);
    set_req(2, 0, 4'hF, 32'h8, 0);
    for (int k = 0; k < 4; k++) begin
      at_neg;
      chk("prio_spi_gnt", gnt_o, 3'b001);
      step;
    end
    req_i[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg;
      chk("prio_rr_gnt", gnt_o, 32'd1 << (1 + (k % 2)));
      step;
    end
    clr;
`endif

    step; step;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data SRAM in top_core between three requesters: the SPI slave memory-write path (index 0), the core data port (index 1) and the core instruction-fetch port (index 2).
- Each requester uses a req/gnt/rvalid handshake. Grant is combinational in the same cycle; the response arrives exactly one cycle after grant.
- Sits between the requesters and the SRAM macro. It lets SPI program loads (e.g. writes to 0x80..) proceed safely while fetch_enable is high.

Parameters:
- N_REQ, 3, number of requesters; index 0 = SPI, 1 = data, 2 = instr.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width (must be 32).
- MEM_BASE, 32'h0000_0000, byte base address of the SRAM window.
- MEM_WORDS, 1024, SRAM depth in words; AW = $clog2(MEM_WORDS).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  N_REQ  request per requester
- we_i  in  N_REQ  write enable per requester
- be_i  in  4*N_REQ  byte enables; slice i = be_i[4i+3:4i]
- addr_i  in  ADDR_W*N_REQ  byte addresses, sliced as for be_i
- wdata_i  in  DATA_W*N_REQ  write data
- gnt_o  out  N_REQ  one-hot grant (combinational)
- rvalid_o  out  N_REQ  one-hot response valid, registered
- rdata_o  out  DATA_W  shared read data, qualified by rvalid_o
- err_o  out  1  response error, qualified by rvalid_o
- mem_req_o  out  1  SRAM chip enable
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  AW  SRAM word address
- mem_wdata_o  out  DATA_W  SRAM write data
- mem_rdata_i  in  DATA_W  SRAM read data, valid the cycle after mem_req_o

Behaviour:
- Reset (rst_ni low at posedge clk_i):
  - last_q = N_REQ-1, so index 0 has first priority.
  - rvalid_o = 0, err_o = 0, pending-owner register cleared.
  - Combinational outputs are all 0 while no req_i is high.
- Arbitration, each cycle:
  - Search req_i starting at (last_q+1) mod N_REQ and wrapping. The first set bit wins and gnt_o is one-hot for that index.
  - No requests: gnt_o = 0, mem_req_o = 0.
  - On a grant, last_q <= winner at the clock edge; otherwise last_q holds.
- Address decode for winner w:
  - off = addr_i[w] - MEM_BASE.
  - In range if addr_i[w] >= MEM_BASE and off>>2 < MEM_WORDS.
  - mem_addr_o = off[AW+1:2]; addr bits [1:0] are ignored.
- In-range grant:
  - mem_req_o = 1; mem_we_o, mem_be_o, mem_wdata_o come from requester w.
- Out-of-range grant:
  - Still granted, but mem_req_o = 0.
  - err flag registered for the response; write data is discarded.
- Response:
  - Registers owner_q = w, valid_q = 1, err_q.
  - Next cycle: rvalid_o[owner_q] = 1 and err_o = err_q.
  - rdata_o = mem_rdata_i for an in-range read, else 0. Writes also produce an rvalid, and rdata_o is don't-care (driven 0).
- Back-to-back: a new grant can occur in every cycle. Response N is presented in the same cycle as grant N+1, with no stall.
- Requester rule: request inputs must stay stable until gnt_o. The arbiter never revokes a grant.
- Reset mid-operation: an in-flight response is dropped (no rvalid_o), and arbitration restarts at index 0.
- Width rule: unsigned compare; subtraction underflow means out of range.

Optional Feature:
- MEM_ARB_SPI_PRIO_EN defined:
  - Requester 0 (SPI) wins whenever req_i[0] = 1, regardless of last_q.
  - Indices 1..2 round-robin among themselves only.
  - last_q updates only on grants to 1..2.
- Not defined: pure round-robin over all N_REQ as above.

Decomposition:
- Package mem_arb_pkg holds:
  - localparams REQ_SPI = 0, REQ_DATA = 1, REQ_INSTR = 2, N_REQ_DEF = 3, BE_W = 4.
  - typedef req_idx_t (logic [$clog2(N_REQ)-1:0]).
- One sub-module, rr_pick, is natural: N-wide request vector plus last index in, one-hot grant plus index out, purely combinational. It is instantiated once, or twice when MEM_ARB_SPI_PRIO_EN is defined.

Test Plan:
- Single SPI write, addr 0x80, data 0x00000fff, be 0xF -> gnt_o = 3'b001 in the same cycle; mem_addr_o = 0x20; rvalid_o = 3'b001 next cycle with err_o = 0. An instr read of 0x80 then returns 0x00000fff.
- All three requesting continuously from reset -> grant order 0,1,2,0,1,2. Each rvalid_o matches the previous cycle's gnt_o.
- Out-of-range read, addr 0x00001000 with MEM_WORDS = 1024 -> granted, mem_req_o = 0; next cycle rvalid_o set, err_o = 1, rdata_o = 0.
- Byte write, be 4'b0010, data 0xAABBCCDD to a word holding 0 -> read back 0x0000CC00.
- rst_ni low in the cycle after a data-port grant -> no rvalid_o that cycle. The next simultaneous 0/2 request grants index 0 first.
- With MEM_ARB_SPI_PRIO_EN, req_i held at 3'b111 -> SPI granted every cycle. Drop req_i[0] -> the order becomes 1,2,1,2.
